// File: rtl/adder_pkg.sv
// Shared prefix-adder types and helpers: pg pair, black/grey cells, level and latency math.
package adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    function automatic int prefix_levels(input int width);
        return $clog2(width);
    endfunction

    // Pre-processing register + one register per REG_EVERY levels (excluding the last) + output register.
    function automatic int pipe_latency(input int width, input int reg_every);
        return 2 + (prefix_levels(width) - 1) / reg_every;
    endfunction

    function automatic pg_t black(input pg_t hi, input pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    function automatic logic grey(input pg_t hi, input logic g_lo);
        return hi.g | (hi.p & g_lo);
    endfunction

endpackage

// File: rtl/sklansky_level.sv
// One combinational Sklansky prefix level; position 0 is the carry-in node.
module sklansky_level
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEVEL = 0
) (
    input  logic [WIDTH-1:0] i_g,
    input  logic [WIDTH-1:0] i_p,
    output logic [WIDTH-1:0] o_g,
    output logic [WIDTH-1:0] o_p
);

    for (genvar j = 0; j < WIDTH; j++) begin : g_pos
        if (((j >> LEVEL) % 2) == 1) begin : g_black
            // Last node of the preceding 2^LEVEL block.
            localparam int LO = ((j >> (LEVEL + 1)) << (LEVEL + 1)) + (1 << LEVEL) - 1;
            pg_t w_c;
            assign w_c    = black(pg_t'{g: i_g[j], p: i_p[j]}, pg_t'{g: i_g[LO], p: i_p[LO]});
            assign o_g[j] = w_c.g;
            assign o_p[j] = w_c.p;
        end else begin : g_pass
            assign o_g[j] = i_g[j];
            assign o_p[j] = i_p[j];
        end
    end

endmodule

// File: rtl/sklansky_pipe_adder.sv
// Pipelined Sklansky adder with global-stall valid/ready stream and in-order tag.
// Define SKLANSKY_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module sklansky_pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [TAG_W-1:0] out_tag
`ifdef SKLANSKY_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int L   = prefix_levels(WIDTH);
    localparam int LAT = pipe_latency(WIDTH, REG_EVERY);

    logic           w_adv;
    logic [LAT-1:0] r_vld_pipe;

    assign w_adv     = !r_vld_pipe[LAT-1] | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld_pipe[LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_vld_pipe <= '0;
        else if (w_adv) r_vld_pipe <= {r_vld_pipe[LAT-2:0], in_valid};
    end

    // Node 0 is cin (p=0); node i+1 is bit i. Bit WIDTH-1 only feeds the final grey cell.
    logic [WIDTH-1:0] r_ng0, r_np0, r_po0;
    logic             r_gt0;
    logic [TAG_W-1:0] r_tag0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ng0  <= '0;
            r_np0  <= '0;
            r_po0  <= '0;
            r_gt0  <= 1'b0;
            r_tag0 <= '0;
        end else if (w_adv) begin
            r_ng0  <= {a[WIDTH-2:0] & b[WIDTH-2:0], cin};
            r_np0  <= {a[WIDTH-2:0] ^ b[WIDTH-2:0], 1'b0};
            r_po0  <= a ^ b;
            r_gt0  <= a[WIDTH-1] & b[WIDTH-1];
            r_tag0 <= in_tag;
        end
    end

    logic [L-1:0][WIDTH-1:0] w_ng_in, w_np_in, w_ng_out, w_np_out, w_po_in;
    logic [L-1:0][TAG_W-1:0] w_tag_in;
    logic [L-1:0]            w_gt_in;

    assign w_ng_in[0]  = r_ng0;
    assign w_np_in[0]  = r_np0;
    assign w_po_in[0]  = r_po0;
    assign w_gt_in[0]  = r_gt0;
    assign w_tag_in[0] = r_tag0;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        sklansky_level #(.WIDTH(WIDTH), .LEVEL(k)) u_level (
            .i_g (w_ng_in[k]),
            .i_p (w_np_in[k]),
            .o_g (w_ng_out[k]),
            .o_p (w_np_out[k])
        );
        if (k > 0) begin : g_link
            if (k % REG_EVERY == 0) begin : g_reg
                logic [WIDTH-1:0] r_ng, r_np, r_po;
                logic             r_gt;
                logic [TAG_W-1:0] r_tag;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_ng  <= '0;
                        r_np  <= '0;
                        r_po  <= '0;
                        r_gt  <= 1'b0;
                        r_tag <= '0;
                    end else if (w_adv) begin
                        r_ng  <= w_ng_out[k-1];
                        r_np  <= w_np_out[k-1];
                        r_po  <= w_po_in[k-1];
                        r_gt  <= w_gt_in[k-1];
                        r_tag <= w_tag_in[k-1];
                    end
                end
                assign w_ng_in[k]  = r_ng;
                assign w_np_in[k]  = r_np;
                assign w_po_in[k]  = r_po;
                assign w_gt_in[k]  = r_gt;
                assign w_tag_in[k] = r_tag;
            end else begin : g_wire
                assign w_ng_in[k]  = w_ng_out[k-1];
                assign w_np_in[k]  = w_np_out[k-1];
                assign w_po_in[k]  = w_po_in[k-1];
                assign w_gt_in[k]  = w_gt_in[k-1];
                assign w_tag_in[k] = w_tag_in[k-1];
            end
        end
    end

    // After the full tree, node i holds the carry into bit i; every group p includes cin's p=0.
    logic [WIDTH-1:0] w_carry;
    logic             w_cout;
    logic             w_unused_p;

    assign w_carry    = w_ng_out[L-1];
    assign w_cout     = grey(pg_t'{g: w_gt_in[L-1], p: w_po_in[L-1][WIDTH-1]}, w_carry[WIDTH-1]);
    assign w_unused_p = |w_np_out[L-1];

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [TAG_W-1:0] r_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_tag  <= '0;
        end else if (w_adv) begin
            r_sum  <= w_po_in[L-1] ^ w_carry;
            r_cout <= w_cout;
            r_tag  <= w_tag_in[L-1];
        end
    end

    assign sum     = r_sum;
    assign cout    = r_cout;
    assign out_tag = r_tag;

`ifdef SKLANSKY_PIPE_OVF_EN
    logic r_ovf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_ovf <= 1'b0;
        else if (w_adv) r_ovf <= w_carry[WIDTH-1] ^ w_cout;
    end
    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_sklansky_pipe_adder.sv
// Scoreboard bench for sklansky_pipe_adder (WIDTH=32, REG_EVERY=2): arithmetic model, decoupled monitor.
module tb_sklansky_pipe_adder;

    localparam int W       = 32;
    localparam int R       = 2;
    localparam int TW      = 4;
    localparam int LAT_EXP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          cout;
    logic [TW-1:0] out_tag;
`ifdef SKLANSKY_PIPE_OVF_EN
    logic          ovf;
`endif

    always #5 clk = ~clk;

    sklansky_pipe_adder #(.WIDTH(W), .REG_EVERY(R), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .out_tag   (out_tag)
`ifdef SKLANSKY_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
        logic [TW-1:0] tag;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    exp_t          m_e;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    bit            chk_lat = 0;
    bit            rand_rdy = 0;
    logic [TW-1:0] tag_ctr = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                   input logic [TW-1:0] t, input int n);
        exp_t       e;
        logic [W:0] s;
        s      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.sum  = s[W-1:0];
        e.cout = s[W];
        e.ovf  = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
        e.tag  = t;
        e.cyc  = n;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rst_n && in_valid && in_ready) q.push_back(model(a, b, cin, in_tag, cyc));

    logic [W+TW:0] held;
    bit            stalled = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 0;
        end else begin
            if (stalled && out_valid) chk("hold_stable", {sum, cout, out_tag}, held);
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            stalled = out_valid && !out_ready;
            held    = {sum, cout, out_tag};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got tag %0h sum %0h, want no output", out_tag, sum);
                end else begin
                    m_e = q.pop_front();
                    chk("sum", sum, m_e.sum);
                    chk("cout", cout, m_e.cout);
                    chk("tag", out_tag, m_e.tag);
`ifdef SKLANSKY_PIPE_OVF_EN
                    chk("ovf", ovf, m_e.ovf);
`endif
                    if (chk_lat) chk("latency", cyc - m_e.cyc, LAT_EXP);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        bit acc = 0;
        a        = x;
        b        = y;
        cin      = c;
        in_tag   = tag_ctr;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        tag_ctr++;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, want accept");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [63:0] t;
        t = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return t[W-1:0];
        endcase
    endfunction

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_tag", out_tag, 0);
`ifdef SKLANSKY_PIPE_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed corners and a nibble-replicated sweep, streamed back to back.
        chk_lat = 1;
        send('1, 32'h1, 1'b0);
        send(32'h7FFF_FFFF, 32'h1, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        send('0, '0, 1'b1);
        send('1, '1, 1'b1);
        send('1, '0, 1'b1);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                for (int c = 0; c < 2; c++) begin
                    logic [3:0] ni, nj;
                    logic [31:0] cc;
                    ni = i[3:0];
                    nj = j[3:0];
                    cc = c;
                    send({8{ni}}, {8{nj}}, cc[0]);
                end
        drain();
        chk_lat = 0;

        // Fill with the consumer blocked, hold 5 cycles, then release.
        out_ready = 1'b0;
        for (int i = 0; i < LAT_EXP; i++) send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_in_ready", in_ready, 0);
            chk("full_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset with a full pipeline: everything in flight is discarded.
        out_ready = 1'b0;
        for (int i = 0; i < LAT_EXP; i++) send(rnd_op() | 32'h1, rnd_op(), 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_tag", out_tag, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("postrst_out_valid", out_valid, 0);
        chk("postrst_in_ready", in_ready, 1);

        // Randomised stream with random consumer back-pressure and input gaps.
        rand_rdy = 1;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        end
        rand_rdy = 0;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: got no completion by 1ms, want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sklansky_pipe_adder.md
# sklansky_pipe_adder

Parametrised, pipelined Sklansky parallel-prefix adder with carry-in, carry-out and a valid/ready stream interface. It generalises the fixed 4-bit combinational Sklansky adder to any `WIDTH`, with configurable register insertion between prefix levels and an in-order sideband tag. It sits in arithmetic datapaths wherever a wide add must close timing at high clock rates.

## Interface
- `WIDTH`, 32: operand width in bits, ≥ 2.
- `REG_EVERY`, 1: number of prefix levels between pipeline registers, ≥ 1.
- `TAG_W`, 1: width of the sideband tag carried alongside each operation, ≥ 1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active low.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block accepts operands this cycle.
- `a`, `b`  in  WIDTH  operands (unsigned/two's complement).
- `cin`  in  1  carry-in.
- `in_tag`  in  TAG_W  sideband, returned unmodified with the result.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  WIDTH  (a + b + cin) mod 2^WIDTH.
- `cout`  out  1  carry out of bit WIDTH-1.
- `out_tag`  out  TAG_W  tag of this result.
- `ovf`  out  1  signed overflow (present only with macro, see Configuration).

## Operation
- Pre-processing: p[i] = a[i]^b[i], g[i] = a[i]&b[i]; cin enters as prefix position −1 with p = 0, g = cin.
- Prefix tree: Sklansky over the WIDTH positions {cin, 0..WIDTH-2}; L = clog2(WIDTH) levels. At level k, every position whose bit k of index (relative to cin) is 1 combines with the last position of the preceding 2^k block using a black cell: g = g_hi | p_hi&g_lo, p = p_hi&p_lo. All other positions pass through unchanged.
- Post-processing: sum[i] = p[i] ^ G[i-1], with G[-1] = cin; cout = g[W-1] | p[W-1]&G[W-2] (grey cell).
- Pipeline registers sit at: the output of pre-processing, after every prefix level k (1-based) with k % REG_EVERY == 0 and k < L, and at the outputs. Each register stage holds a valid bit, the p/g vectors, the original p vector and the tag.
- Flow control uses a global stall: `adv = !out_valid | out_ready`. All stages load only when `adv` = 1. `in_ready = adv`, which is combinational from `out_ready`. A transfer occurs on in_valid & in_ready; a stage's valid bit loads its predecessor's valid bit.
- Bubbles are not collapsed. Results leave strictly in issue order with their tags.
- While out_valid = 1 and out_ready = 0, sum, cout, out_tag and ovf hold stable.

## Timing
- Latency LAT = 2 + floor((L−1)/REG_EVERY) cycles from an accepted input to out_valid, assuming no stall. WIDTH=8/REG_EVERY=1 gives 4; WIDTH=32/REG_EVERY=1 gives 6; WIDTH=32/REG_EVERY=2 gives 4; WIDTH=4/REG_EVERY=1 gives 3.
- Throughput is one operation per cycle when out_ready = 1.
- Reset: all valid bits are 0 and all data registers 0 immediately on rst_n low; in_ready = 1, out_valid = 0, sum = 0, cout = 0, out_tag = 0, ovf = 0. Reset mid-operation discards every in-flight operation, and no result is emitted for it.
- Simultaneous input accept and output drain in the same cycle are legal; occupancy is unchanged.

## Configuration
- `SKLANSKY_PIPE_OVF_EN` defined: `ovf` port exists. ovf = G[W-2] ^ cout (carry into MSB xor carry out), registered with sum, reset 0.
- Undefined: `ovf` port and its logic are absent. All other behaviour and the latency are identical.

## Structure
- Shared package `adder_pkg`:
  - pg pair typedef;
  - functions `prefix_levels(width)` and `pipe_latency(width, reg_every)`;
  - black/grey cell functions.
- One sub-module, `sklansky_level`: a single combinational prefix level parametrised by WIDTH and level index. It is instantiated L times by generate, with an optional register after each instance.

## Test plan
- WIDTH=8, REG_EVERY=1: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, out_valid exactly 4 cycles after accept.
- WIDTH=8 with macro: a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80 → sum=8'h00, cout=1, ovf=1.
- WIDTH=4: exhaustive 512 (a, b, cin) combinations back-to-back with out_ready=1 → every result matches the model, in order with incrementing tags, 1 per cycle.
- Fill the pipeline, then hold out_ready=0 for 5 cycles → in_ready=0, outputs stable, no drop or duplication after release.
- Assert rst_n low with 3 operations in flight → out_valid=0 and sum=0 at once; after release in_ready=1 and no stale result appears.
- WIDTH=32, REG_EVERY=2: 1000 random ops with random out_ready → latency 4 when unstalled, results and tags match the model.
